// File: rtl/pll_pi_filter.sv
// SOGI-PLL loop filter: omega = W_NOM + KP*vq + sum(KI_TS*vq), computed by a
// multi-cycle multiply/scale/accumulate FSM with output clamp and anti-windup.
module pll_pi_filter #(
    parameter int DATA_WIDTH = 32,
    parameter int FP_WIDTH   = 16,
    parameter int KP         = 6553600,
    parameter int KI_TS      = 32768,
    parameter int W_NOM      = 20588742,
    parameter int OMEGA_MAX  = 26765361,
    parameter int OMEGA_MIN  = 14412087
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_data_valid,
    output logic                         in_data_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_data_valid,
    input  logic                         out_data_ready,
    output logic                         sat
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic signed [PW-1:0]         KP_W      = KP;
    localparam logic signed [PW-1:0]         KI_W      = KI_TS;
    localparam logic signed [EW-1:0]         W_NOM_E   = W_NOM;
    localparam logic signed [EW-1:0]         MAX_E     = OMEGA_MAX;
    localparam logic signed [EW-1:0]         MIN_E     = OMEGA_MIN;
    localparam logic signed [DATA_WIDTH-1:0] W_NOM_D   = W_NOM;
    localparam logic signed [DATA_WIDTH-1:0] MAX_D     = OMEGA_MAX;
    localparam logic signed [DATA_WIDTH-1:0] MIN_D     = OMEGA_MIN;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        SCALE = 3'd2,
        SUM   = 3'd3,
        OUT   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t state, state_next;
    logic   armed;

    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [PW-1:0]         p_full, i_full;
    logic signed [EW-1:0]         p_e, inc_e;
    logic signed [EW-1:0]         integ, integ_next;
    logic signed [EW-1:0]         raw;

    logic take;
    logic over_max, under_min;
    logic inc_pos, inc_neg;

    // State register; armed keeps in_data_ready low for the first cycle out of reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (take) state_next = MUL;
            MUL:     state_next = SCALE;
            SCALE:   state_next = SUM;
            SUM:     state_next = OUT;
            OUT:     state_next = HOLD;
            HOLD:    if (out_data_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_data_ready  = (state == IDLE) && armed;
        out_data_valid = (state == HOLD);
        take           = in_data_valid && in_data_ready;
        over_max       = (raw > MAX_E);
        under_min      = (raw < MIN_E);
        inc_pos        = !inc_e[EW-1] && (|inc_e);
        inc_neg        = inc_e[EW-1];
    end

    // Datapath: one arithmetic step per state; the shifts are plain bit slices
    // of the signed products, i.e. arithmetic shift truncating toward -inf.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q        <= '0;
            p_full     <= '0;
            i_full     <= '0;
            p_e        <= '0;
            inc_e      <= '0;
            integ      <= '0;
            integ_next <= '0;
            raw        <= '0;
            out_data   <= W_NOM_D;
            sat        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) x_q <= in_data;
                end
                MUL: begin
                    p_full <= PW'(x_q) * KP_W;
                    i_full <= PW'(x_q) * KI_W;
                end
                SCALE: begin
                    p_e   <= p_full[FP_WIDTH +: EW];
                    inc_e <= i_full[FP_WIDTH +: EW];
                end
                SUM: begin
                    integ_next <= integ + inc_e;
                    raw        <= W_NOM_E + p_e + integ + inc_e;
                end
                OUT: begin
                    if (over_max) begin
                        out_data <= MAX_D;
                        sat      <= 1'b1;
                    end else if (under_min) begin
                        out_data <= MIN_D;
                        sat      <= 1'b1;
                    end else begin
                        out_data <= raw[DATA_WIDTH-1:0];
                        sat      <= 1'b0;
                    end
                    // Anti-windup: freeze the integrator only when it would deepen the violation.
                    if (!((over_max && inc_pos) || (under_min && inc_neg)))
                        integ <= integ_next;
                end
                HOLD: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_pi_filter.sv
// Directed self-checking bench for pll_pi_filter: reset, gains, truncation,
// clamps with anti-windup, throughput, backpressure and mid-operation reset.
module tb_pll_pi_filter;

    localparam logic signed [31:0] W_NOM_V = 32'sd20588742;
    localparam logic signed [31:0] MAX_V   = 32'sd26765361;
    localparam logic signed [31:0] MIN_V   = 32'sd14412087;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic signed [31:0] in_data = '0;
    logic               in_data_valid = 1'b0;
    logic               in_data_ready;
    logic signed [31:0] out_data;
    logic               out_data_valid;
    logic               out_data_ready = 1'b0;
    logic               sat;

    int vectors = 0;
    int miscompares = 0;

    pll_pi_filter dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_data_ready  (in_data_ready),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_data_ready (out_data_ready),
        .sat            (sat)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        in_data_valid = 1'b0;
        out_data_ready = 1'b0;
        cyc();
        Reset = 1'b0;
    endtask

    // One full transaction; lat = cycles from capture edge to valid, -1 on timeout.
    task automatic send(input logic signed [31:0] x, output logic signed [31:0] y,
                        output logic s, output int lat);
        int n;
        lat = -1;
        y = '0;
        s = 1'b0;
        n = 0;
        while (!in_data_ready && n < 50) begin cyc(); n++; end
        if (!in_data_ready) return;
        in_data = x;
        in_data_valid = 1'b1;
        cyc();
        in_data_valid = 1'b0;
        in_data = '0;
        n = 0;
        while (!out_data_valid && n < 20) begin cyc(); n++; end
        if (!out_data_valid) return;
        lat = n;
        y = out_data;
        s = sat;
        out_data_ready = 1'b1;
        cyc();
        out_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic signed [31:0] y;
        logic s;
        int lat;
        Reset = 1'b1;
        cyc();
        vectors++;
        if (out_data !== W_NOM_V || out_data_valid !== 1'b0 || in_data_ready !== 1'b0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%0d valid=%b ready=%b sat=%b expected out=%0d valid=0 ready=0 sat=0",
                     out_data, out_data_valid, in_data_ready, sat, W_NOM_V);
        end
        Reset = 1'b0;
        #1;
        vectors++;
        if (in_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b expected 0", in_data_ready);
        end
        cyc();
        vectors++;
        if (in_data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_first_edge: got %b expected 1", in_data_ready);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== W_NOM_V || s !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_in: got out=%0d sat=%b expected out=%0d sat=0", y, s, W_NOM_V);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_pi_gain();
        logic signed [31:0] y;
        logic s;
        int lat;
        do_reset();
        send(32'sh0000_1000, y, s, lat);
        vectors++;
        if (y !== 32'sd21000390 || s !== 1'b0) begin
            miscompares++;
            $display("FAIL pi_first: got out=%0d sat=%b expected out=21000390 sat=0", y, s);
        end
        send(32'sh0000_1000, y, s, lat);
        vectors++;
        if (y !== 32'sd21002438 || s !== 1'b0) begin
            miscompares++;
            $display("FAIL pi_second: got out=%0d sat=%b expected out=21002438 sat=0", y, s);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== 32'sd20592838) begin
            miscompares++;
            $display("FAIL integ_4096: got %0d expected 20592838", y);
        end
    endtask

    task automatic test_neg_truncation();
        logic signed [31:0] y;
        logic s;
        int lat;
        do_reset();
        send(-32'sd1, y, s, lat);
        vectors++;
        if (y !== 32'sd20588641 || s !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_lsb: got out=%0d sat=%b expected out=20588641 sat=0", y, s);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== 32'sd20588741) begin
            miscompares++;
            $display("FAIL neg_integ: got %0d expected 20588741", y);
        end
    endtask

    task automatic test_sat_max();
        logic signed [31:0] y;
        logic s;
        int lat;
        do_reset();
        send(32'sh0001_0000, y, s, lat);
        vectors++;
        if (y !== MAX_V || s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_max: got out=%0d sat=%b expected out=%0d sat=1", y, s, MAX_V);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== W_NOM_V || s !== 1'b0) begin
            miscompares++;
            $display("FAIL windup_max: got out=%0d sat=%b expected out=%0d sat=0", y, s, W_NOM_V);
        end
    endtask

    task automatic test_sat_min();
        logic signed [31:0] y;
        logic s;
        int lat;
        do_reset();
        send(-32'sh0001_0000, y, s, lat);
        vectors++;
        if (y !== MIN_V || s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_min: got out=%0d sat=%b expected out=%0d sat=1", y, s, MIN_V);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== W_NOM_V || s !== 1'b0) begin
            miscompares++;
            $display("FAIL windup_min: got out=%0d sat=%b expected out=%0d sat=0", y, s, W_NOM_V);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1;
        second = -1;
        do_reset();
        in_data = '0;
        in_data_valid = 1'b1;
        out_data_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (out_data_valid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        in_data_valid = 1'b0;
        out_data_ready = 1'b0;
        vectors++;
        if (first < 0 || second - first !== 6) begin
            miscompares++;
            $display("FAIL throughput: got pulses at %0d and %0d expected 6 cycles apart", first, second);
        end
        vectors++;
        if (out_data !== W_NOM_V) begin
            miscompares++;
            $display("FAIL b2b_out: got %0d expected %0d", out_data, W_NOM_V);
        end
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        cyc();
        in_data = 32'sh0000_1000;
        in_data_valid = 1'b1;
        cyc();
        in_data = 32'sd0;
        n = 0;
        while (!out_data_valid && n < 20) begin cyc(); n++; end
        vectors++;
        if (out_data_valid !== 1'b1 || out_data !== 32'sd21000390) begin
            miscompares++;
            $display("FAIL bp_first: got out=%0d valid=%b expected out=21000390 valid=1", out_data, out_data_valid);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (out_data !== 32'sd21000390 || out_data_valid !== 1'b1 || in_data_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got out=%0d valid=%b ready=%b expected out=21000390 valid=1 ready=0",
                         i, out_data, out_data_valid, in_data_ready);
            end
        end
        out_data_ready = 1'b1;
        cyc();
        out_data_ready = 1'b0;
        vectors++;
        if (out_data_valid !== 1'b0 || in_data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_data_valid, in_data_ready);
        end
        cyc();
        in_data_valid = 1'b0;
        vectors++;
        if (in_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_pending_taken: got ready=%b expected 0", in_data_ready);
        end
        n = 0;
        while (!out_data_valid && n < 20) begin cyc(); n++; end
        vectors++;
        if (out_data !== 32'sd20590790 || n !== 4) begin
            miscompares++;
            $display("FAIL bp_second: got out=%0d lat=%0d expected out=20590790 lat=4", out_data, n);
        end
        out_data_ready = 1'b1;
        cyc();
        out_data_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] y;
        logic s;
        int lat;
        int stray;
        do_reset();
        send(32'sh0000_1000, y, s, lat);
        send(32'sh0000_1000, y, s, lat);
        in_data = 32'sh0000_1000;
        in_data_valid = 1'b1;
        cyc();
        in_data_valid = 1'b0;
        cyc();
        cyc();
        Reset = 1'b1;
        #1;
        vectors++;
        if (out_data_valid !== 1'b0 || out_data !== W_NOM_V || in_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got out=%0d valid=%b ready=%b expected out=%0d valid=0 ready=0",
                     out_data, out_data_valid, in_data_ready, W_NOM_V);
        end
        cyc();
        Reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_data_valid) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL mid_no_output: got %0d valid cycles expected 0", stray);
        end
        send(32'sd0, y, s, lat);
        vectors++;
        if (y !== W_NOM_V || s !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_integ_cleared: got out=%0d sat=%b expected out=%0d sat=0", y, s, W_NOM_V);
        end
    endtask

    initial begin
        test_reset();
        test_pi_gain();
        test_neg_truncation();
        test_sat_max();
        test_sat_min();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
